ch4_noise_gen: RTL and testbench

//  Consumer side of the channel-4 register file: takes the decoded NR41..NR44 fields and produces the noise sample.

---
 rtl/ch4_noise_gen_pkg.sv | 44 ++++
 rtl/ch4_noise_gen_if.sv | 36 +++
 rtl/ch4_noise_gen_envelope.sv | 73 +++++++
 rtl/ch4_noise_gen.sv | 134 +++++++++++++
 tb/tb_ch4_noise_gen.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ch4_noise_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ch4_pkg
// Brief   : Shared types and helpers for the channel-4 noise generator:
//           FSM state type, LFSR width, divider period and LFSR step.
// Revision: 1.0  initial release
// ============================================================================
package ch4_pkg;

  // Channel run state
  typedef enum logic [0:0] {
    OFF = 1'b0,
    RUN = 1'b1
  } ch4_state_e;

  localparam int LFSR_W    = 15;
  // Width of the period value; 112<<13 fits, larger shifts only occur
  // with the divider held, so their truncation never matters.
  localparam int CH4_DIV_W = 22;

  // Divider period in clk cycles: (r==0 ? 8 : 16*r) << s
  function automatic logic [CH4_DIV_W-1:0] ch4_period(input logic [2:0] r,
                                                      input logic [3:0] s);
    logic [CH4_DIV_W-1:0] base;
    base = (r == 3'd0) ? CH4_DIV_W'(8) : CH4_DIV_W'({r, 4'b0000});
    return base << s;
  endfunction

  // One LFSR shift: feedback bit0^bit1 into bit14, and into bit6 in 7-bit mode
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] lfsr,
                                                  input logic              short_mode);
    logic              x;
    logic [LFSR_W-1:0] n;
    x         = lfsr[0] ^ lfsr[1];
    n         = lfsr >> 1;
    n[LFSR_W-1] = x;
    if (short_mode) begin
      n[6] = x;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ch4_noise_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : ch4_noise_gen_if
// Brief   : Decoded NR41..NR44 fields and strobes from the register block to
//           the noise generator, plus the generator's DAC/status outputs.
//           master = register block / mixer side, slave = noise generator.
// Revision: 1.0  initial release
// ============================================================================
interface ch4_noise_gen_if;
  logic       tick_64hz;
  logic       ch4_restart;
  logic [3:0] env_init;
  logic       env_up;
  logic [2:0] env_pace;
  logic [3:0] clk_shift;
  logic       lfsr_short;
  logic [2:0] div_code;
  logic       length_en;
  logic       length_expired;
  logic [3:0] ch4_out;
  logic       ch4_active;
  logic       dac_en;

  modport master (
    output tick_64hz, ch4_restart, env_init, env_up, env_pace,
           clk_shift, lfsr_short, div_code, length_en, length_expired,
    input  ch4_out, ch4_active, dac_en
  );

  modport slave (
    input  tick_64hz, ch4_restart, env_init, env_up, env_pace,
           clk_shift, lfsr_short, div_code, length_en, length_expired,
    output ch4_out, ch4_active, dac_en
  );
endinterface
`default_nettype wire

// File: rtl/ch4_noise_gen_envelope.sv
`default_nettype none
// ============================================================================
// Module  : ch4_envelope
// Brief   : Volume envelope: pace counter advanced by the 64 Hz tick, volume
//           stepping up/down with saturation. Once a step is attempted at the
//           limit, stepping stops until the next load (restart).
// Revision: 1.0  initial release
// ============================================================================
module ch4_envelope
  import ch4_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       apu_reset,
  input  wire logic       load,
  input  wire logic       tick,
  input  wire logic [3:0] init,
  input  wire logic       up,
  input  wire logic [2:0] pace,
  output logic      [3:0] volume
);

  logic [2:0] pace_cnt_q, pace_cnt_d;
  logic [3:0] vol_q, vol_d;
  logic       done_q, done_d;
  logic [3:0] pace_inc;

  // Widened so the compare against pace has no wrap when pace is lowered live
  assign pace_inc = {1'b0, pace_cnt_q} + 4'd1;

  // Next envelope state: load wins, pace==0 freezes, otherwise count ticks
  always_comb begin
    pace_cnt_d = pace_cnt_q;
    vol_d      = vol_q;
    done_d     = done_q;
    if (load) begin
      pace_cnt_d = 3'd0;
      vol_d      = init;
      done_d     = 1'b0;
    end else if (pace == 3'd0) begin
      pace_cnt_d = 3'd0;
    end else if (tick && !done_q) begin
      if (pace_inc >= {1'b0, pace}) begin
        pace_cnt_d = 3'd0;
        if (up && (vol_q != 4'd15)) begin
          vol_d = vol_q + 4'd1;
        end else if (!up && (vol_q != 4'd0)) begin
          vol_d = vol_q - 4'd1;
        end else begin
          done_d = 1'b1;
        end
      end else begin
        pace_cnt_d = pace_inc[2:0];
      end
    end
  end

  // Envelope registers
  always_ff @(posedge clk or posedge apu_reset) begin
    if (apu_reset) begin
      pace_cnt_q <= 3'd0;
      vol_q      <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      pace_cnt_q <= pace_cnt_d;
      vol_q      <= vol_d;
      done_q     <= done_d;
    end
  end

  assign volume = vol_q;

endmodule
`default_nettype wire

// File: rtl/ch4_noise_gen.sv
`default_nettype none
// ============================================================================
// Module  : ch4_noise_gen
// Brief   : Channel-4 noise generator: frequency divider, 15-bit LFSR,
//           volume envelope (ch4_envelope) and OFF/RUN channel control.
//           Produces the registered 4-bit DAC sample for the APU mixer.
// Config  : CH4_LFSR_DEBUG_EN adds output lfsr_q (live LFSR) and input
//           dbg_step (one forced LFSR step per clk while high).
// Revision: 1.0  initial release
// ============================================================================
module ch4_noise_gen
  import ch4_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF,
  parameter int                DIV_W     = 22
) (
  input  wire logic              clk,
  input  wire logic              apu_reset,
`ifdef CH4_LFSR_DEBUG_EN
  input  wire logic              dbg_step,
  output logic      [LFSR_W-1:0] lfsr_q,
`endif
  ch4_noise_gen_if.slave         bus
);

  ch4_state_e        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_state_q, lfsr_state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [3:0]        ch4_out_q, ch4_out_d;
  logic [3:0]        volume;
  logic [DIV_W-1:0]  period;
  logic              dac_en;
  logic              restart;
  logic              div_hold;
  logic              div_step;
  logic              dbg_force;
  logic              env_tick;

  assign dac_en   = (bus.env_init != 4'd0) || bus.env_up;
  assign restart  = bus.ch4_restart;
  // Shifts 14 and 15 park the divider so the LFSR never advances
  assign div_hold = (bus.clk_shift >= 4'd14);
  assign period   = DIV_W'(ch4_period(bus.div_code, bus.clk_shift));
  // A restart in the same cycle swallows the envelope tick
  assign env_tick = bus.tick_64hz && (state_q == RUN) && !restart;

`ifdef CH4_LFSR_DEBUG_EN
  assign dbg_force = dbg_step;
  assign lfsr_q    = lfsr_state_q;
`else
  assign dbg_force = 1'b0;
`endif

  // Channel FSM: DAC off dominates, then restart, then length expiry
  always_comb begin
    state_d = state_q;
    if (!dac_en) begin
      state_d = OFF;
    end else if (restart) begin
      state_d = RUN;
    end else if ((state_q == RUN) && bus.length_en && bus.length_expired) begin
      state_d = OFF;
    end
  end

  // Frequency divider: reload on restart and on each underflow, sampling
  // the live period at reload time
  always_comb begin
    div_cnt_d = div_cnt_q;
    div_step  = 1'b0;
    if (restart) begin
      div_cnt_d = period;
    end else if ((state_q == RUN) && !div_hold) begin
      if (div_cnt_q <= DIV_W'(1)) begin
        div_cnt_d = period;
        div_step  = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q - DIV_W'(1);
      end
    end
  end

  // LFSR: re-seed on restart, else step on divider underflow; the mode bit
  // is read live so a mode change takes effect on the next step
  always_comb begin
    lfsr_state_d = lfsr_state_q;
    if (restart) begin
      lfsr_state_d = LFSR_SEED;
    end else if (div_step || dbg_force) begin
      lfsr_state_d = lfsr_next(lfsr_state_q, bus.lfsr_short);
    end
  end

  // Output sample: needs RUN both now and next so the DAC goes silent on the
  // same edge the channel turns off, and never shows a pre-seed LFSR bit
  always_comb begin
    ch4_out_d = 4'd0;
    if ((state_q == RUN) && (state_d == RUN) && !lfsr_state_q[0]) begin
      ch4_out_d = volume;
    end
  end

  // State, divider, LFSR and output registers
  always_ff @(posedge clk or posedge apu_reset) begin
    if (apu_reset) begin
      state_q      <= OFF;
      lfsr_state_q <= LFSR_SEED;
      div_cnt_q    <= '0;
      ch4_out_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      lfsr_state_q <= lfsr_state_d;
      div_cnt_q    <= div_cnt_d;
      ch4_out_q    <= ch4_out_d;
    end
  end

  ch4_envelope u_envelope (
    .clk       (clk),
    .apu_reset (apu_reset),
    .load      (restart),
    .tick      (env_tick),
    .init      (bus.env_init),
    .up        (bus.env_up),
    .pace      (bus.env_pace),
    .volume    (volume)
  );

  assign bus.ch4_out    = ch4_out_q;
  assign bus.ch4_active = (state_q == RUN);
  assign bus.dac_en     = dac_en;

endmodule
`default_nettype wire

// File: tb/tb_ch4_noise_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_ch4_noise_gen
// Brief   : Self-checking bench for ch4_noise_gen: table vectors, directed
//           multi-cycle sequences and randomized stimulus against a
//           behavioural reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_ch4_noise_gen;

  logic clk = 1'b0;
  logic apu_reset;

  ch4_noise_gen_if bus ();

  always #5 clk = ~clk;

`ifdef CH4_LFSR_DEBUG_EN
  logic        dbg_step = 1'b0;
  logic [14:0] lfsr_dbg;
  ch4_noise_gen dut (.clk(clk), .apu_reset(apu_reset), .dbg_step(dbg_step),
                     .lfsr_q(lfsr_dbg), .bus(bus));
`else
  ch4_noise_gen dut (.clk(clk), .apu_reset(apu_reset), .bus(bus));
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state (plain integers)
  bit m_run;
  int m_lfsr, m_vol, m_pcnt, m_wait, m_out;
  bit m_stop;

  int rec [2200];

  typedef struct {
    bit       rs;
    bit [3:0] init;
    bit       up;
    bit       len_en;
    bit       len_exp;
    bit       e_dac;
    bit       e_act;
    bit [3:0] e_out;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int period_of(int r, int s);
    return (r == 0 ? 8 : 16 * r) << s;
  endfunction

  function automatic int lfsr_step(int v, bit sh);
    int x;
    x = (v % 2) ^ ((v / 2) % 2);
    v = v / 2 + x * 16384;
    if (sh) v = (v & ~64) | (x * 64);
    return v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_lfsr = 32767; m_vol = 0; m_pcnt = 0;
    m_wait = 0; m_out = 0; m_stop = 0;
  endtask

  // Advance the model by one clock edge using the current input values
  task automatic model_edge();
    bit dac, rs, nrun;
    int r, s;
    dac = (bus.env_init != 0) || bus.env_up;
    rs  = bus.ch4_restart;
    r   = int'(bus.div_code);
    s   = int'(bus.clk_shift);
    if (!dac) nrun = 0;
    else if (rs) nrun = 1;
    else if (m_run && bus.length_en && bus.length_expired) nrun = 0;
    else nrun = m_run;
    m_out = (m_run && nrun && (m_lfsr % 2 == 0)) ? m_vol : 0;
    if (rs) begin
      m_lfsr = 32767; m_wait = period_of(r, s);
      m_vol = int'(bus.env_init); m_pcnt = 0; m_stop = 0;
    end else begin
      if (m_run && s < 14) begin
        m_wait--;
        if (m_wait <= 0) begin
          m_lfsr = lfsr_step(m_lfsr, bus.lfsr_short);
          m_wait = period_of(r, s);
        end
      end
      if (bus.env_pace == 0) m_pcnt = 0;
      else if (bus.tick_64hz && m_run && !m_stop) begin
        m_pcnt++;
        if (m_pcnt >= int'(bus.env_pace)) begin
          m_pcnt = 0;
          if (bus.env_up && m_vol < 15) m_vol++;
          else if (!bus.env_up && m_vol > 0) m_vol--;
          else m_stop = 1;
        end
      end
    end
    m_run = nrun;
  endtask

  // One clock: check dac_en, step the model, check registered outputs
  task automatic cyc();
    #1;
    check("dac_en", int'(bus.dac_en), (bus.env_init != 0 || bus.env_up) ? 1 : 0);
    model_edge();
    @(posedge clk);
    #1;
    check("ch4_out", int'(bus.ch4_out), m_out);
    check("ch4_active", int'(bus.ch4_active), int'(m_run));
  endtask

  task automatic pulse_restart();
    bus.ch4_restart = 1'b1;
    cyc();
    bus.ch4_restart = 1'b0;
  endtask

  // Run until ch4_out is non-zero; returns the cycle count (0 on timeout)
  task automatic wait_nonzero(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      cyc();
      if (bus.ch4_out != 4'd0) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, mism, nz, inact, zeros;

    apu_reset = 1'b1;
    bus.tick_64hz = 1'b0; bus.ch4_restart = 1'b0; bus.env_init = 4'd0;
    bus.env_up = 1'b0; bus.env_pace = 3'd0; bus.clk_shift = 4'd0;
    bus.lfsr_short = 1'b0; bus.div_code = 3'd0; bus.length_en = 1'b0;
    bus.length_expired = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", int'(bus.ch4_out), 0);
    check("reset_active", int'(bus.ch4_active), 0);
    check("reset_dac", int'(bus.dac_en), 0);
    apu_reset = 1'b0;

    // ---- table vectors: DAC gating, restart, length expiry ----
    tbl[0] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[2] = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    tbl[3] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    tbl[4] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[5] = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    tbl[6] = '{1'b0, 4'd15, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[7] = '{1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0};
    tbl[8] = '{1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0};
    tbl[9] = '{1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0};
    for (int i = 0; i < 10; i++) begin
      bus.ch4_restart    = tbl[i].rs;
      bus.env_init       = tbl[i].init;
      bus.env_up         = tbl[i].up;
      bus.length_en      = tbl[i].len_en;
      bus.length_expired = tbl[i].len_exp;
      cyc();
      check($sformatf("tbl%0d_dac", i), int'(bus.dac_en), int'(tbl[i].e_dac));
      check($sformatf("tbl%0d_active", i), int'(bus.ch4_active), int'(tbl[i].e_act));
      check($sformatf("tbl%0d_out", i), int'(bus.ch4_out), int'(tbl[i].e_out));
    end
    bus.ch4_restart = 1'b0; bus.length_en = 1'b0; bus.length_expired = 1'b0;

    // ---- first audible sample and envelope down with saturation ----
    bus.env_init = 4'd2; bus.env_up = 1'b0; bus.env_pace = 3'd1;
    pulse_restart();
    wait_nonzero(n);
    check("first_out_cycle", n, 121);
    check("first_out_value", int'(bus.ch4_out), 2);
    for (int t = 0; t < 3; t++) begin
      bus.tick_64hz = 1'b1; cyc();
      bus.tick_64hz = 1'b0; cyc();
      check($sformatf("env_down_tick%0d", t), int'(bus.ch4_out), (t == 0) ? 1 : 0);
    end

    // ---- pace 0 freezes volume, then length expiry silences at once ----
    bus.env_init = 4'd9; bus.env_pace = 3'd0;
    pulse_restart();
    wait_nonzero(n);
    check("second_out_cycle", n, 121);
    for (int t = 0; t < 10; t++) begin
      bus.tick_64hz = 1'b1; cyc();
      bus.tick_64hz = 1'b0; cyc();
    end
    check("pace0_frozen", int'(bus.ch4_out), 9);
    bus.length_en = 1'b1; bus.length_expired = 1'b1;
    cyc();
    check("len_exp_active", int'(bus.ch4_active), 0);
    check("len_exp_out", int'(bus.ch4_out), 0);
    bus.length_en = 1'b0; bus.length_expired = 1'b0;

    // ---- 7-bit mode repeats every 127 steps, 15-bit mode does not ----
    for (int mode = 1; mode >= 0; mode--) begin
      bus.env_init = 4'd15; bus.lfsr_short = mode[0];
      pulse_restart();
      repeat (100) cyc();
      mism = 0; zeros = 0;
      for (int t = 0; t < 2100; t++) begin
        cyc();
        rec[t] = int'(bus.ch4_out);
        if (rec[t] == 0) zeros++;
      end
      for (int t = 0; t < 1084; t++) if (rec[t] != rec[t + 1016]) mism++;
      if (mode == 1) begin
        check("short_period_127", mism, 0);
        check("short_nonconst", (zeros > 0 && zeros < 2100) ? 1 : 0, 1);
      end else begin
        check("long_not_127", (mism > 0) ? 1 : 0, 1);
      end
    end
    bus.lfsr_short = 1'b0;

    // ---- shift 14 freezes the LFSR ----
    bus.clk_shift = 4'd14;
    pulse_restart();
    nz = 0; inact = 0;
    for (int t = 0; t < 20000; t++) begin
      cyc();
      if (bus.ch4_out != 4'd0) nz++;
      if (!bus.ch4_active) inact++;
    end
    check("s14_frozen_out", nz, 0);
    check("s14_still_active", inact, 0);

    // ---- asynchronous reset mid-run ----
    bus.clk_shift = 4'd0;
    pulse_restart();
    wait_nonzero(n);
    check("pre_reset_cycle", n, 121);
    #2;
    apu_reset = 1'b1;
    #1;
    check("async_rst_out", int'(bus.ch4_out), 0);
    check("async_rst_active", int'(bus.ch4_active), 0);
    model_reset();
    @(posedge clk);
    #1;
    apu_reset = 1'b0;
    repeat (20) cyc();

    // ---- randomized segments against the model ----
    for (int seg = 0; seg < 40; seg++) begin
      bus.div_code   = 3'($urandom_range(0, 7));
      bus.clk_shift  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(14, 15))
                                                    : 4'($urandom_range(0, 2));
      bus.lfsr_short = 1'($urandom_range(0, 1));
      bus.env_init   = 4'($urandom_range(0, 15));
      bus.env_up     = 1'($urandom_range(0, 1));
      bus.env_pace   = 3'($urandom_range(0, 7));
      bus.length_en  = 1'($urandom_range(0, 1));
      bus.tick_64hz  = 1'b0; bus.length_expired = 1'b0;
      pulse_restart();
      for (int i = 0; i < 300; i++) begin
        bus.ch4_restart    = ($urandom_range(0, 99) == 0);
        bus.tick_64hz      = ($urandom_range(0, 3) == 0);
        bus.length_expired = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 199) == 0) bus.env_init = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 199) == 0) bus.env_up = ~bus.env_up;
        if ($urandom_range(0, 99) == 0) bus.env_pace = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 149) == 0) bus.lfsr_short = ~bus.lfsr_short;
        cyc();
      end
      bus.ch4_restart = 1'b0; bus.tick_64hz = 1'b0; bus.length_expired = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
